// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for stream_demux.
// STREAM_DEMUX_HIZ_EN selects a tri-state idle value for empty channels instead of zero.
package stream_demux_pkg;

  localparam int STREAM_DEMUX_MAX_M = 32;

  function automatic int sel_width(input int m);
    return $clog2(m);
  endfunction

`ifdef STREAM_DEMUX_HIZ_EN
  localparam logic IDLE_BIT = 1'bz;
`else
  localparam logic IDLE_BIT = 1'b0;
`endif

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
// The slot drives the package idle value on its data output while it is empty.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] data_in,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] data_out,
  output logic         can_load
);

  logic         vld;
  logic [N-1:0] data;

  // A load on the same edge as a drain wins, so the slot stays full with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= data_in;
    end else if (vld && ready) begin
      vld <= 1'b0;
    end
  end

  assign can_load = !vld || ready;
  assign valid    = vld;
  assign data_out = vld ? data : {N{IDLE_BIT}};

endmodule

// File: rtl/stream_demux.sv
// Handshaked 1:M demultiplexer with a one-entry holding register per channel.
// Build with STREAM_DEMUX_HIZ_EN to float idle channel outputs instead of driving zero.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int M  = 8,
  localparam int SW = sel_width(M)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [N-1:0]        In,
  input  logic [SW-1:0]       Select,
  input  logic                Broadcast,
  input  logic                InValid,
  output logic                InReady,
  output logic [M-1:0][N-1:0] Out,
  output logic [M-1:0]        OutValid,
  input  logic [M-1:0]        OutReady,
  output logic                Busy
);

  logic [M-1:0] can_load;
  logic [M-1:0] load;
  logic         accept;

  // Valid/ready: a word moves when valid and ready are both high at a rising edge.
  // InReady is a function of slot state, Select, Broadcast and OutReady only, never of
  // InValid; a broadcast is accepted only when every slot can take it in the same edge.
  assign InReady = Broadcast ? (&can_load) : can_load[Select];
  assign accept  = InValid && InReady;
  assign Busy    = |OutValid;

  for (genvar i = 0; i < M; i++) begin : g_slot
    assign load[i] = accept && (Broadcast || (Select == SW'(i)));

    demux_slot #(.N(N)) u_slot (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .load     (load[i]),
      .data_in  (In),
      .ready    (OutReady[i]),
      .valid    (OutValid[i]),
      .data_out (Out[i]),
      .can_load (can_load[i])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed vector table, hand-written corner
// sequences, and randomized traffic checked against per-channel expected queues.
module tb_stream_demux;

  localparam int N  = 16;
  localparam int M  = 8;
  localparam int SW = 3;

  logic                Clk = 1'b0;
  logic                Reset_n;
  logic [N-1:0]        In;
  logic [SW-1:0]       Select;
  logic                Broadcast;
  logic                InValid;
  logic                InReady;
  logic [M-1:0][N-1:0] Out;
  logic [M-1:0]        OutValid;
  logic [M-1:0]        OutReady;
  logic                Busy;

  int n_checks = 0;
  int n_errors = 0;

  stream_demux #(.N(N), .M(M)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .In        (In),
    .Select    (Select),
    .Broadcast (Broadcast),
    .InValid   (InValid),
    .InReady   (InReady),
    .Out       (Out),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [SW-1:0] sel;
    logic          bc;
    logic          iv;
    logic [N-1:0]  din;
    logic [M-1:0]  ordy;
    logic          exp_ir;
    logic [M-1:0]  exp_ov;
    int            ch;
    logic [N-1:0]  exp_dat;
  } vec_t;

  vec_t vecs [11];

  logic [N-1:0] exp_q [M][$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [SW-1:0] sel, input logic bc, input logic iv,
                       input logic [N-1:0] din, input logic [M-1:0] ordy);
    Select    = sel;
    Broadcast = bc;
    InValid   = iv;
    In        = din;
    OutReady  = ordy;
  endtask

  task automatic rand_cycle(input bit drain);
    logic                pred_ir;
    logic [M-1:0]        exp_ov;
    logic [M-1:0][N-1:0] exp_out;
    @(negedge Clk);
    if (drain)
      drive('0, 1'b0, 1'b0, '0, '1);
    else
      drive(SW'($urandom_range(0, M - 1)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0), N'($urandom), M'($urandom));
    #1;
    pred_ir = 1'b1;
    for (int i = 0; i < M; i++) begin
      exp_ov[i]  = (exp_q[i].size() != 0);
      exp_out[i] = exp_ov[i] ? exp_q[i][0] : '0;
      if (Broadcast || (int'(Select) == i))
        if (exp_ov[i] && !OutReady[i]) pred_ir = 1'b0;
    end
    check("rand_inready", 128'(InReady), 128'(pred_ir));
    check("rand_outvalid", 128'(OutValid), 128'(exp_ov));
    check("rand_out", 128'(Out), 128'(exp_out));
    check("rand_busy", 128'(Busy), 128'(|exp_ov));
    for (int i = 0; i < M; i++)
      if (exp_ov[i] && OutReady[i]) void'(exp_q[i].pop_front());
    if (InValid && pred_ir)
      for (int i = 0; i < M; i++)
        if (Broadcast || (int'(Select) == i)) exp_q[i].push_back(In);
  endtask

  initial begin
    int acc;

    vecs[0]  = '{3'd5, 1'b0, 1'b1, 16'hBEEF, 8'h00, 1'b1, 8'h20, 5, 16'hBEEF};
    vecs[1]  = '{3'd2, 1'b0, 1'b1, 16'h1111, 8'h00, 1'b1, 8'h24, 2, 16'h1111};
    vecs[2]  = '{3'd2, 1'b0, 1'b1, 16'h2222, 8'h00, 1'b0, 8'h24, 2, 16'h1111};
    vecs[3]  = '{3'd6, 1'b0, 1'b1, 16'h6666, 8'h00, 1'b1, 8'h64, 6, 16'h6666};
    vecs[4]  = '{3'd1, 1'b0, 1'b1, 16'h0001, 8'h00, 1'b1, 8'h66, 1, 16'h0001};
    vecs[5]  = '{3'd1, 1'b0, 1'b1, 16'h0002, 8'h02, 1'b1, 8'h66, 1, 16'h0002};
    vecs[6]  = '{3'd7, 1'b0, 1'b1, 16'h7777, 8'h00, 1'b1, 8'hE6, 7, 16'h7777};
    vecs[7]  = '{3'd0, 1'b1, 1'b1, 16'hAAAA, 8'h00, 1'b0, 8'hE6, 0, 16'h0000};
    vecs[8]  = '{3'd0, 1'b1, 1'b1, 16'hAAAA, 8'hFF, 1'b1, 8'hFF, 3, 16'hAAAA};
    vecs[9]  = '{3'd0, 1'b0, 1'b0, 16'h5555, 8'hFF, 1'b1, 8'h00, 0, 16'h0000};
    vecs[10] = '{3'd3, 1'b0, 1'b0, 16'h5555, 8'h00, 1'b1, 8'h00, 4, 16'h0000};

    // Reset state
    Reset_n = 1'b0;
    drive('0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outvalid", 128'(OutValid), 128'(0));
    check("reset_busy", 128'(Busy), 128'(0));
    check("reset_inready", 128'(InReady), 128'(1));
    check("reset_out", 128'(Out), 128'(0));
    @(negedge Clk);
    Reset_n = 1'b1;

    // Directed vector table
    for (int v = 0; v < 11; v++) begin
      @(negedge Clk);
      drive(vecs[v].sel, vecs[v].bc, vecs[v].iv, vecs[v].din, vecs[v].ordy);
      #1;
      check($sformatf("vec%0d_inready", v), 128'(InReady), 128'(vecs[v].exp_ir));
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d_outvalid", v), 128'(OutValid), 128'(vecs[v].exp_ov));
      check($sformatf("vec%0d_out", v), 128'(Out[vecs[v].ch]), 128'(vecs[v].exp_dat));
      check($sformatf("vec%0d_busy", v), 128'(Busy), 128'(|vecs[v].exp_ov));
    end

    // Back-to-back burst to channel 1 via drain+reload
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      drive(3'd1, 1'b0, 1'b1, N'(16'h0100 + k), 8'h02);
      #1;
      if (InReady) acc++;
      check("burst_inready", 128'(InReady), 128'(1));
      @(posedge Clk);
      #1;
      check("burst_out", 128'(Out[1]), 128'(16'h0100 + k));
      check("burst_outvalid", 128'(OutValid), 128'(8'h02));
    end
    check("burst_accepts", 128'(acc), 128'(10));
    @(negedge Clk);
    drive(3'd1, 1'b0, 1'b0, '0, 8'h02);
    @(posedge Clk);
    #1;
    check("burst_drained", 128'(OutValid), 128'(0));

    // Reset asserted while channel 3 holds a word and a new offer is pending
    @(negedge Clk);
    drive(3'd3, 1'b0, 1'b1, 16'h3333, 8'h00);
    @(posedge Clk);
    #1;
    check("pre_reset_outvalid", 128'(OutValid), 128'(8'h08));
    @(negedge Clk);
    drive(3'd3, 1'b0, 1'b1, 16'h4444, 8'h00);
    #1;
    check("pre_reset_inready", 128'(InReady), 128'(0));
    Reset_n = 1'b0;
    #1;
    check("midreset_outvalid", 128'(OutValid), 128'(0));
    check("midreset_busy", 128'(Busy), 128'(0));
    check("midreset_inready", 128'(InReady), 128'(1));
    check("midreset_out3", 128'(Out[3]), 128'(0));
    Broadcast = 1'b1;
    #1;
    check("midreset_bc_inready", 128'(InReady), 128'(1));
    @(posedge Clk);
    #1;
    check("midreset_hold", 128'(OutValid), 128'(0));
    @(negedge Clk);
    drive('0, 1'b0, 1'b0, '0, '0);
    Reset_n = 1'b1;

    // Randomized traffic against the queue model
    for (int i = 0; i < M; i++) exp_q[i].delete();
    for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 3; c++) rand_cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
